router_fifo: RTL and testbench



---
 rtl/router_pkg.sv | 16 +
 rtl/router_fifo.sv | 102 ++++++++++
 tb/tb_router_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: widths, depths and the stored FIFO entry layout.
package router_pkg;

  localparam int ROUTER_DWIDTH     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ROUTER_NUM_DEST   = 3;

  // Payload length lives in header[7:2].
  localparam int PKT_LEN_LSB = 2;

  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the router. Stores each byte with a header
// tag (taken from the delayed lfd_state) and tracks the remaining packet length
// on the read side so data_out returns to zero once a packet has drained.
// Optional macro ROUTER_FIFO_OCC_EN adds a combinational occupancy output.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int DWIDTH = ROUTER_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty
`ifdef ROUTER_FIFO_OCC_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            lfd_d;
  logic [6:0]      pkt_cnt;
  logic            clr_pend;

  logic            wr_go;
  logic            rd_go;
  logic [DWIDTH:0] rd_entry;
  logic [6:0]      hdr_len;

  // The MSB of each pointer is a wrap bit distinguishing full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_go    = write_enb && !full;
  assign rd_go    = read_enb && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  // Header length field plus one for the trailing parity byte.
  assign hdr_len  = 7'(rd_entry[DWIDTH-1:PKT_LEN_LSB]) + 7'd1;

`ifdef ROUTER_FIFO_OCC_EN
  assign occupancy = wr_ptr - rd_ptr;
`endif

  // Delay lfd_state one cycle so the tag lines up with the header byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfd_d <= 1'b0;
    else     lfd_d <= lfd_state;
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_go && !soft_reset) mem[wr_ptr[AW-1:0]] <= {lfd_d, data_in};
  end

  // Pointers, packet length counter and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      clr_pend <= 1'b0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      clr_pend <= 1'b0;
      data_out <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_go) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        data_out <= rd_entry[DWIDTH-1:0];
        if (rd_entry[DWIDTH]) begin
          pkt_cnt  <= hdr_len;
          clr_pend <= 1'b0;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt  <= pkt_cnt - 7'd1;
          clr_pend <= (pkt_cnt == 7'd1);
        end else begin
          clr_pend <= 1'b0;
        end
      end else begin
        // Last byte of the packet was read last cycle and no new read follows.
        if (clr_pend) data_out <= '0;
        clr_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: the stimulus tasks push expected read
// bytes into a queue and an independent monitor compares them against
// data_out one cycle after each accepted read. Flags and clears are checked
// directly. Occupancy checks are active when ROUTER_FIFO_OCC_EN is defined.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_OCC_EN
  logic [4:0] occupancy;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  bit         rd_expect = 1'b0;

  router_fifo #(.DEPTH(DEPTH), .DWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_OCC_EN
    ,
    .occupancy  (occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_occ(input string name, input logic [31:0] req);
`ifdef ROUTER_FIFO_OCC_EN
    check(name, 32'(occupancy), req);
`endif
  endtask

  // One clock of stimulus; updates the reference queue and the scoreboard.
  task automatic cyc(input bit we, input bit re, input bit lfd, input bit sr, input logic [7:0] d);
    bit can_rd;
    bit can_wr;
    @(negedge clk);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    soft_reset = sr;
    data_in    = d;
    can_rd     = (model.size() > 0);
    can_wr     = (model.size() < DEPTH);
    rd_expect  = 1'b0;
    if (sr) begin
      model.delete();
    end else begin
      if (re && can_rd) begin
        exp_q.push_back(model.pop_front());
        rd_expect = 1'b1;
      end
      if (we && can_wr) model.push_back(d);
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare data_out one cycle after every accepted read.
  initial begin
    bit s;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      s = rd_expect;
      #1;
      if (s) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    #1 rst = 1'b1;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", 32'(data_out), 32'h00);
    check_occ("rst_occ", 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Packet with header 0D (length 3): header, 3 payload, parity
    cyc(0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h0D);
    cyc(1, 0, 0, 0, 8'h11);
    cyc(1, 0, 0, 0, 8'h22);
    cyc(1, 0, 0, 0, 8'h33);
    cyc(1, 0, 0, 0, 8'h0C);
    check("pkt_not_empty", 32'(empty), 32'd0);
    repeat (5) cyc(0, 1, 0, 0, 8'h00);
    check("pkt_last_byte", 32'(data_out), 32'h0C);
    cyc(0, 0, 0, 0, 8'h00);
    check("pkt_end_clear", 32'(data_out), 32'h00);
    check("pkt_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation
    cyc(1, 0, 0, 0, 8'h41);
    cyc(1, 0, 0, 0, 8'h42);
    cyc(1, 1, 0, 0, 8'h43);
    cyc(0, 1, 0, 0, 8'h00);
    check("pre_rst_data", 32'(data_out), 32'h42);
    #1;
    write_enb = 1'b0; read_enb = 1'b0; rd_expect = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_data", 32'(data_out), 32'h00);
    check_occ("async_rst_occ", 32'd0);
    model.delete();
    @(negedge clk) rst = 1'b0;
    cyc(0, 0, 0, 0, 8'h00);
    check("post_rst_empty", 32'(empty), 32'd1);

    // Fill to full, drop the 17th write, drain in order
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h10 + i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_not_empty", 32'(empty), 32'd0);
    check_occ("fill_occ", 32'd16);
    cyc(1, 0, 0, 0, 8'hEE);
    check("drop_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 8'h00);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_full", 32'(full), 32'd0);
    cyc(0, 1, 0, 0, 8'h00);
    check("empty_read_hold", 32'(data_out), 32'h1F);

    // Simultaneous read and write while full
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h60 + i));
    check("full2", 32'(full), 32'd1);
    cyc(1, 1, 0, 0, 8'hAA);
    check("rw_full_deassert", 32'(full), 32'd0);
    check_occ("rw_full_occ", 32'd15);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 8'h00);
    check("rw_full_empty", 32'(empty), 32'd1);

    // Soft reset wins over a same-cycle write
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'h81 + i));
    cyc(1, 0, 0, 1, 8'h77);
    check("soft_empty", 32'(empty), 32'd1);
    check("soft_data", 32'(data_out), 32'h00);
    check_occ("soft_occ", 32'd0);
    cyc(0, 0, 0, 0, 8'h00);
    check("soft_still_empty", 32'(empty), 32'd1);
    cyc(1, 0, 0, 0, 8'h5A);
    cyc(0, 1, 0, 0, 8'h00);
    check("soft_after_empty", 32'(empty), 32'd1);

    // Occupancy and pointer wrap with paired traffic
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 8'(8'hC0 + i));
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    check_occ("occ_7w2r", 32'd5);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, 0, 8'(i * 7 + 3));
      check_occ("occ_wrap", 32'd5);
    end
    check("wrap_full", 32'(full), 32'd0);
    check("wrap_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 8'h00);
    check("wrap_drained", 32'(empty), 32'd1);
    cyc(0, 0, 0, 0, 8'h00);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
